// File: rtl/add2.sv
// Registered ripple-carry adder: {cout, s} <= a + b + cin one cycle after in_valid.
// WIDTH=1 gives a single registered full-adder cell.
module add2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH-1:0] s_comb;
  logic             cout_comb;
  logic             carry;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

  // Ripple chain of full-adder cells; carry walks from bit 0 upward.
  always_comb begin
    s_comb = '0;
    carry  = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s_comb[i] = a[i] ^ b[i] ^ carry;
      carry     = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    cout_comb = carry;
  end

  // Result registers load only on accepted samples so idle-cycle X never reaches s/cout.
  always_comb begin
    s_d         = s_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      s_d    = s_comb;
      cout_d = cout_comb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add2.sv
// Self-checking bench for add2 at WIDTH=1 and WIDTH=4 against an arithmetic model
// plus hand-computed literal expectations.
module tb_add2;

  logic       clk;
  logic       rst_n;
  logic       iv1, a1, b1, cin1;
  logic       s1, cout1, ov1;
  logic       iv4, cin4;
  logic [3:0] a4, b4;
  logic [3:0] s4;
  logic       cout4, ov4;

  int vectors;
  int miscompares;
  bit running;

  // Model state
  logic       ms1, mc1, mv1;
  logic [3:0] ms4;
  logic       mc4, mv4;

  add2 #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .out_valid(ov1)
  );

  add2 #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .a(a4), .b(b4), .cin(cin4),
    .s(s4), .cout(cout4), .out_valid(ov4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the registered (WIDTH+1)-bit sum of the last accepted sample.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {mc1, ms1} <= 2'b00;
      mv1        <= 1'b0;
      {mc4, ms4} <= 5'b0;
      mv4        <= 1'b0;
    end else begin
      mv1 <= iv1;
      mv4 <= iv4;
      if (iv1) {mc1, ms1} <= 2'(a1) + 2'(b1) + 2'(cin1);
      if (iv4) {mc4, ms4} <= 5'(a4) + 5'(b4) + 5'(cin4);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(posedge clk) begin
    #3;
    if (running) begin
      check("model w1 s", 32'(s1), 32'(ms1));
      check("model w1 cout", 32'(cout1), 32'(mc1));
      check("model w1 valid", 32'(ov1), 32'(mv1));
      check("model w4 s", 32'(s4), 32'(ms4));
      check("model w4 cout", 32'(cout4), 32'(mc4));
      check("model w4 valid", 32'(ov4), 32'(mv4));
    end
  end

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    iv4 = v; a4 = a; b4 = b; cin4 = c;
  endtask

  logic [7:0] s_tab;
  logic [7:0] c_tab;

  initial begin
    vectors = 0; miscompares = 0; running = 1'b0;
    s_tab = 8'b1001_0110;
    c_tab = 8'b1110_1000;
    rst_n = 1'b0;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    iv4 = 1'b1; a4 = 4'd1; b4 = 4'd1; cin4 = 1'b1;
    #1 running = 1'b1;

    // Reset held with valid inputs: nothing captured.
    for (int i = 0; i < 3; i++) begin
      after_edge();
      check("reset s", 32'(s1), 32'd0);
      check("reset cout", 32'(cout1), 32'd0);
      check("reset valid", 32'(ov1), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    after_edge();
    check("release w1 s", 32'(s1), 32'd1);
    check("release w1 cout", 32'(cout1), 32'd1);
    check("release w1 valid", 32'(ov1), 32'd1);
    check("release w4 s", 32'(s4), 32'd3);

    // WIDTH=1 truth table, back-to-back.
    iv4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {a1, b1, cin1} = 3'(i);
      after_edge();
      check("truth s", 32'(s1), 32'(s_tab[i]));
      check("truth cout", 32'(cout1), 32'(c_tab[i]));
      check("truth valid", 32'(ov1), 32'd1);
    end
    @(negedge clk);
    iv1 = 1'b0;

    // WIDTH=4 ripple cases.
    drive4(1'b1, 4'b1011, 4'b1000, 1'b0);
    after_edge();
    check("ripple1 s", 32'(s4), 32'b0011);
    check("ripple1 cout", 32'(cout4), 32'd1);
    drive4(1'b1, 4'b1111, 4'b0000, 1'b1);
    after_edge();
    check("ripple2 s", 32'(s4), 32'b0000);
    check("ripple2 cout", 32'(cout4), 32'd1);
    check("idle w1 valid", 32'(ov1), 32'd0);

    // Hold with X inputs while idle.
    drive4(1'b1, 4'b0101, 4'b0010, 1'b0);
    after_edge();
    check("hold cap s", 32'(s4), 32'b0111);
    drive4(1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
    for (int i = 0; i < 2; i++) begin
      after_edge();
      check("hold s", 32'(s4), 32'b0111);
      check("hold cout", 32'(cout4), 32'd0);
      check("hold valid", 32'(ov4), 32'd0);
    end

    // Async reset between edges while a result is valid.
    drive4(1'b1, 4'b1001, 4'b1000, 1'b1);
    @(posedge clk);
    #2;
    check("pre-reset s", 32'(s4), 32'b0010);
    check("pre-reset valid", 32'(ov4), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async s", 32'(s4), 32'd0);
    check("async cout", 32'(cout4), 32'd0);
    check("async valid", 32'(ov4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive4(1'b1, 4'b0110, 4'b0011, 1'b1);
    after_edge();
    check("post-reset s", 32'(s4), 32'b1010);
    iv4 = 1'b0;
    after_edge();

    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
